// File: rtl/bip_checker_pkg.sv
// Shared definitions for the BIP checker: FSM encodings, AM byte positions, default widths.
package bip_checker_pkg;
  localparam int LEN_CODED_BLOCK_DEF = 66;
  localparam int NB_BIP_DEF          = 8;
  localparam int NB_ERR_CNT_DEF      = 16;
  localparam int BIP3_BYTE           = 3;
  localparam int BIP7_BYTE           = 7;
  localparam int BIT_CNT_W           = 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    WAIT_AM  = 2'd1,
    CHECK    = 2'd2
  } state_t;

  // First bit of byte k in the [0:65] coded block (after the 2-bit sync header).
  function automatic int byte_lsb(input int k);
    return 2 + 8 * k;
  endfunction
endpackage

// File: rtl/bip_checker_if.sv
// Block/status bundle for bip_checker; o_bit_err_count exists only with BIP_CHECKER_PER_BIT_CNT_EN.
interface bip_checker_if
  import bip_checker_pkg::*;
#(
  parameter int LEN_CODED_BLOCK = LEN_CODED_BLOCK_DEF,
  parameter int NB_BIP          = NB_BIP_DEF,
  parameter int NB_ERR_CNT      = NB_ERR_CNT_DEF
);
  logic [0:LEN_CODED_BLOCK-1] i_data;
  logic                       i_enable;
  logic                       i_valid;
  logic                       i_am_valid;
  logic                       i_lane_locked;
  logic [NB_BIP-1:0]          i_bip_calc;
  logic                       i_clear_counters;
  logic                       o_bip_error;
  logic [NB_ERR_CNT-1:0]      o_bip_err_count;
  logic [NB_ERR_CNT-1:0]      o_am_malformed_count;
  logic                       o_checking;
`ifdef BIP_CHECKER_PER_BIT_CNT_EN
  logic [NB_BIP*BIT_CNT_W-1:0] o_bit_err_count;

  modport master (output i_data, i_enable, i_valid, i_am_valid, i_lane_locked, i_bip_calc,
                         i_clear_counters,
                  input  o_bip_error, o_bip_err_count, o_am_malformed_count, o_checking,
                         o_bit_err_count);
  modport slave  (input  i_data, i_enable, i_valid, i_am_valid, i_lane_locked, i_bip_calc,
                         i_clear_counters,
                  output o_bip_error, o_bip_err_count, o_am_malformed_count, o_checking,
                         o_bit_err_count);
`else
  modport master (output i_data, i_enable, i_valid, i_am_valid, i_lane_locked, i_bip_calc,
                         i_clear_counters,
                  input  o_bip_error, o_bip_err_count, o_am_malformed_count, o_checking);
  modport slave  (input  i_data, i_enable, i_valid, i_am_valid, i_lane_locked, i_bip_calc,
                         i_clear_counters,
                  output o_bip_error, o_bip_err_count, o_am_malformed_count, o_checking);
`endif
endinterface

// File: rtl/bip_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count <= '0;
    else if (clr)                     count <= '0;
    else if (inc && (count != '1))    count <= count + 1'b1;
  end
endmodule

// File: rtl/bip_checker.sv
// AM BIP3 checker: compares received BIP3 against the calculated one per lane.
// Optional per-bit error counters under BIP_CHECKER_PER_BIT_CNT_EN.
module bip_checker
  import bip_checker_pkg::*;
#(
  parameter int LEN_CODED_BLOCK = LEN_CODED_BLOCK_DEF,
  parameter int NB_BIP          = NB_BIP_DEF,
  parameter int NB_ERR_CNT      = NB_ERR_CNT_DEF
) (
  input logic          i_clock,
  input logic          i_reset,
  bip_checker_if.slave bus
);
  localparam int B3 = byte_lsb(BIP3_BYTE);
  localparam int B7 = byte_lsb(BIP7_BYTE);

  state_t            state, state_nxt;
  logic [NB_BIP-1:0] rx_bip3, rx_bip7;
  logic              am_acc, checking, do_check, mal_inc, mismatch, bip_error;

  always_comb begin
    for (int j = 0; j < NB_BIP; j++) begin
      rx_bip3[j] = bus.i_data[B3 + j];
      rx_bip7[j] = bus.i_data[B7 + j];
    end
  end

  assign am_acc = bus.i_enable && bus.i_valid && bus.i_am_valid;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= UNLOCKED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.i_lane_locked) state_nxt = UNLOCKED;
    else begin
      case (state)
        UNLOCKED: state_nxt = WAIT_AM;
        WAIT_AM:  if (am_acc) state_nxt = CHECK;
        CHECK:    state_nxt = CHECK;
        default:  state_nxt = UNLOCKED;
      endcase
    end
  end

  // Losing lock discards any check on the same cycle.
  always_comb begin
    checking = (state == CHECK);
    do_check = checking && am_acc && bus.i_lane_locked;
    mal_inc  = do_check && (rx_bip7 != ~rx_bip3);
    mismatch = do_check && (rx_bip7 == ~rx_bip3) && (rx_bip3 != bus.i_bip_calc);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) bip_error <= 1'b0;
    else          bip_error <= mismatch;
  end

  assign bus.o_bip_error = bip_error;
  assign bus.o_checking  = checking;

  sat_counter #(.WIDTH(NB_ERR_CNT)) u_bip_cnt (
    .clk(i_clock), .rst_n(i_reset), .clr(bus.i_clear_counters),
    .inc(mismatch), .count(bus.o_bip_err_count)
  );

  sat_counter #(.WIDTH(NB_ERR_CNT)) u_mal_cnt (
    .clk(i_clock), .rst_n(i_reset), .clr(bus.i_clear_counters),
    .inc(mal_inc), .count(bus.o_am_malformed_count)
  );

`ifdef BIP_CHECKER_PER_BIT_CNT_EN
  logic [NB_BIP-1:0] bit_inc;
  assign bit_inc = {NB_BIP{mismatch}} & (rx_bip3 ^ bus.i_bip_calc);

  for (genvar j = 0; j < NB_BIP; j++) begin : g_bit
    sat_counter #(.WIDTH(BIT_CNT_W)) u_cnt (
      .clk(i_clock), .rst_n(i_reset), .clr(bus.i_clear_counters),
      .inc(bit_inc[j]), .count(bus.o_bit_err_count[j*BIT_CNT_W +: BIT_CNT_W])
    );
  end
`endif
endmodule
